// File: rtl/demux2_stream.sv
// Registered 1-to-2 stream demultiplexer. Each output port owns a one-entry
// buffer, so a stalled port never blocks beats steered to the other port.
module demux2_stream_port #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_acc,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_ready,
  output logic                 o_valid,
  output logic [WIDTH-1:0]     o_data,
  output logic [CNT_WIDTH-1:0] o_cnt
);
  typedef enum logic {EMPTY, FULL} state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_data;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic                 w_drain;

  assign w_drain = (r_state == FULL) & i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_drain) r_cnt <= r_cnt + 1'b1;
      case (r_state)
        EMPTY: if (i_acc) begin
          r_state <= FULL;
          r_data  <= i_data;
        end
        FULL: begin
          // An accept into a full port only happens alongside a drain: pass-through.
          if (i_acc)        r_data  <= i_data;
          else if (w_drain) r_state <= EMPTY;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state == FULL);
  assign o_data  = r_data;
  assign o_cnt   = r_cnt;
endmodule

module demux2_stream #(
  parameter int WIDTH     = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic                 i_in_sel,
  input  logic [WIDTH-1:0]     i_in_data,
  output logic                 o_out0_valid,
  input  logic                 i_out0_ready,
  output logic [WIDTH-1:0]     o_out0_data,
  output logic                 o_out1_valid,
  input  logic                 i_out1_ready,
  output logic [WIDTH-1:0]     o_out1_data,
  output logic [CNT_WIDTH-1:0] o_cnt0,
  output logic [CNT_WIDTH-1:0] o_cnt1
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]                w_vld;
  logic [NUM_PORTS-1:0]                w_rdy;
  logic [NUM_PORTS-1:0]                w_acc;
  logic [NUM_PORTS-1:0][WIDTH-1:0]     w_data;
  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0] w_cnt;

  assign w_rdy      = {i_out1_ready, i_out0_ready};
  assign o_in_ready = ~w_vld[i_in_sel] | w_rdy[i_in_sel];

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign w_acc[g] = i_in_valid & o_in_ready & (i_in_sel == 1'(g));
    demux2_stream_port #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_port (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_acc  (w_acc[g]),
      .i_data (i_in_data),
      .i_ready(w_rdy[g]),
      .o_valid(w_vld[g]),
      .o_data (w_data[g]),
      .o_cnt  (w_cnt[g])
    );
  end

  assign o_out0_valid = w_vld[0];
  assign o_out1_valid = w_vld[1];
  assign o_out0_data  = w_data[0];
  assign o_out1_data  = w_data[1];
  assign o_cnt0       = w_cnt[0];
  assign o_cnt1       = w_cnt[1];
endmodule

// File: doc/demux2_stream.md
# demux2_stream

Registered 1-to-2 stream demultiplexer with valid/ready handshaking. It is the steering counterpart to the 2:1 selector: one input stream arrives with a per-beat select bit, and each beat is routed to output port 0 or port 1. Each output has its own one-entry register, so a stalled port does not block traffic headed to the other port. Per-port transfer counters support debug and verification.

## Interface
- WIDTH, 2, data width of every beat
- CNT_WIDTH, 8, width of each per-port transfer counter

- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous reset, active-low
- IN_VALID  input  1  input beat present
- IN_READY  output  1  block accepts the beat this cycle
- IN_SEL  input  1  destination of the beat: 0 = port 0, 1 = port 1
- IN_DATA  input  WIDTH  beat payload
- OUT0_VALID / OUT1_VALID  output  1  port register holds a beat
- OUT0_READY / OUT1_READY  input  1  downstream accepts the beat
- OUT0_DATA / OUT1_DATA  output  WIDTH  port register payload
- CNT0 / CNT1  output  CNT_WIDTH  completed output handshakes per port

## Operation
- Each port n has a 2-state buffer FSM.
  - EMPTY: OUTn_VALID=0.
  - FULL: OUTn_VALID=1, and OUTn_DATA holds the payload.
- Input acceptance: accept = IN_VALID & IN_READY.
- IN_READY = ~OUTs_VALID | OUTs_READY, where s = IN_SEL. IN_READY is combinational from IN_SEL, the port-s state, and OUTs_READY. It does not depend on IN_VALID.
- Output handshake: drain_n = OUTn_VALID & OUTn_READY.
- FSM transitions for port n:
  - EMPTY → FULL on accept with IN_SEL=n.
  - FULL → EMPTY on drain_n without an accept to n.
  - FULL → FULL with a new payload on drain_n plus a simultaneous accept to n. This is pass-through at full throughput.
  - FULL holds its payload while OUTn_READY=0.
- A port drains independently of the current IN_SEL. A stalled port never blocks beats destined for the other port.
- Upstream must hold IN_SEL and IN_DATA stable while IN_VALID=1 and the beat has not been accepted. Behaviour is undefined if it does not.
- IN_VALID=0: the input side takes no action. Ports still drain.
- CNTn increments by 1 on every drain_n. It wraps from 2^CNT_WIDTH−1 to 0 with no saturation or flag.
- The non-selected data register never changes on an accept.

## Timing
- RST_N low, asynchronously:
  - both FSMs go to EMPTY
  - OUT0_VALID=OUT1_VALID=0
  - OUT0_DATA=OUT1_DATA=0
  - CNT0=CNT1=0
  - IN_READY=1 for either IN_SEL, because it follows from the empty buffers
- Reset asserted mid-operation discards buffered beats without any handshake. Counters clear.
- Release is synchronous to CLK in the sense that the first state change can happen on the first rising edge with RST_N=1.
- Latency: a beat accepted at edge k appears on OUTn_VALID/OUTn_DATA right after edge k, so it is visible in cycle k+1. It can complete at edge k+1 if OUTn_READY=1.
- Throughput: 1 beat/cycle per port when OUTn_READY is held high. Beats alternating between ports also sustain 1 beat/cycle.
- All state changes occur on the CLK rising edge. There is no combinational path from IN_DATA to the OUT ports.
- IN_READY may be combinational from OUTn_READY, as defined in Operation.

## Test plan
- Reset: drive RST_N=0 mid-stream with port 0 FULL. Required response:
  - OUT0_VALID=0, OUT1_VALID=0, OUT0_DATA=0, OUT1_DATA=0, CNT0=0, CNT1=0 immediately, with no CLK edge needed.
  - IN_READY=1 for IN_SEL=0 and for IN_SEL=1.
- Single beat: IN_SEL=0, IN_DATA=2'b10 for one cycle with OUT0_READY=0. Required response:
  - the next cycle shows OUT0_VALID=1, OUT0_DATA=2'b10, OUT1_VALID=0
  - raising OUT0_READY gives OUT0_VALID=0 one edge later and CNT0=1.
- Streaming: OUT0_READY=1 and four back-to-back beats 0,1,2,3 with IN_SEL=0. Required response:
  - IN_READY stays 1
  - OUT0_DATA shows 0,1,2,3 on consecutive cycles
  - CNT0=4, CNT1=0.
- Backpressure and independence:
  - Hold OUT1_READY=0. Send 2'b01 to port 1, then 2'b11 to port 1. IN_READY must be 0 for the second beat, and OUT1_DATA must stay 2'b01.
  - While port 1 is stalled, send 2'b10 with IN_SEL=0. The beat must be accepted and appear on OUT0.
  - Raise OUT1_READY. 2'b11 must follow 2'b01 on OUT1, and CNT1 must reach 2.
- Simultaneous drain and fill: port 0 FULL with 2'b01, OUT0_READY=1, accept 2'b10 to port 0 in the same cycle. Required response:
  - OUT0_VALID stays 1
  - OUT0_DATA becomes 2'b10 with no empty bubble
  - CNT0 increments by 1.
- Counter wrap: CNT_WIDTH=2, five port-1 transfers. Required response: CNT1 counts 1,2,3,0,1, and CNT0=0 throughout.
